// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests onto an
// 8-bit RAM port and sequences 1/2/4-byte reads and writes one byte per cycle.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_from_if,
    input  logic        ena_from_if,
    input  logic        drop_flag_from_if,
    output logic        ok_flag_to_if,
    output logic [31:0] inst_to_if,
    input  logic        ena_from_lsb,
    input  logic        wr_flag_from_lsb,
    input  logic [31:0] addr_from_lsb,
    input  logic [2:0]  size_from_lsb,
    input  logic [31:0] data_from_lsb,
    output logic        ok_flag_to_lsb,
    output logic [31:0] data_to_lsb,
    input  logic        rollback_flag_from_rob,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);
    typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  stage_q, stage_d;
    logic        if_pending_q, if_pending_d;
    logic        ls_pending_q, ls_pending_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        ls_wr_q, ls_wr_d;
    logic [31:0] ls_addr_q, ls_addr_d;
    logic [2:0]  ls_size_q, ls_size_d;
    logic [31:0] ls_data_q, ls_data_d;
    logic [2:0]  cur_size_q, cur_size_d;
    logic [23:0] cur_data_q, cur_data_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        ok_if_q, ok_if_d;
    logic        ok_lsb_q, ok_lsb_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ldata_q, ldata_d;
    logic [4:0]  cap_sh;
    logic        io_block;
    logic        read_abort;

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        cur_size_d = cur_size_q;
        cur_data_d = cur_data_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        ok_if_d    = 1'b0;
        ok_lsb_d   = 1'b0;
        inst_d     = inst_q;
        ldata_d    = ldata_q;

        // A new pulse overwrites any un-started request; drop/rollback win over it.
        if_pc_d      = ena_from_if ? pc_from_if : if_pc_q;
        if_pending_d = (if_pending_q | ena_from_if) & ~drop_flag_from_if;
        ls_wr_d      = ena_from_lsb ? wr_flag_from_lsb : ls_wr_q;
        ls_addr_d    = ena_from_lsb ? addr_from_lsb : ls_addr_q;
        ls_size_d    = ena_from_lsb ? size_from_lsb : ls_size_q;
        ls_data_d    = ena_from_lsb ? data_from_lsb : ls_data_q;
        ls_pending_d = (ls_pending_q | ena_from_lsb) & ~(rollback_flag_from_rob & ~ls_wr_d);

        io_block   = ls_wr_d && (ls_addr_d[17:16] == 2'b11) && io_buffer_full;
        read_abort = (state_q == IF_READ) ? drop_flag_from_if : rollback_flag_from_rob;
        // Stage s (s>=1) sees byte s-1 on mem_din; stage 4 wraps to lane 3.
        cap_sh     = {stage_q[1:0] - 2'd1, 3'b000};

        case (state_q)
            IDLE: begin
                if (rdy) begin
                    if (ls_pending_d) begin
                        if (!io_block) begin
                            ls_pending_d = 1'b0;
                            cur_size_d   = ls_size_d;
                            mem_a_d      = ls_addr_d;
                            stage_d      = 3'd0;
                            rbuf_d       = 32'd0;
                            if (ls_wr_d) begin
                                mem_dout_d = ls_data_d[7:0];
                                cur_data_d = ls_data_d[31:8];
                                mem_wr_d   = 1'b1;
                                state_d    = LS_WRITE;
                            end else begin
                                state_d = LS_READ;
                            end
                        end
                    end else if (if_pending_d) begin
                        if_pending_d = 1'b0;
                        cur_size_d   = 3'd4;
                        mem_a_d      = if_pc_d;
                        stage_d      = 3'd0;
                        rbuf_d       = 32'd0;
                        state_d      = IF_READ;
                    end
                end
            end
            IF_READ, LS_READ: begin
                if (read_abort) begin
                    state_d = IDLE;
                    stage_d = 3'd0;
                end else begin
                    if (stage_q != 3'd0) begin
                        rbuf_d = rbuf_q | ({24'd0, mem_din} << cap_sh);
                    end
                    if (stage_q == cur_size_q) begin
                        state_d = IDLE;
                        stage_d = 3'd0;
                        if (state_q == IF_READ) begin
                            inst_d  = rbuf_d;
                            ok_if_d = 1'b1;
                        end else begin
                            ldata_d  = rbuf_d;
                            ok_lsb_d = 1'b1;
                        end
                    end else begin
                        stage_d = stage_q + 3'd1;
                        if (stage_q + 3'd1 < cur_size_q) begin
                            mem_a_d = mem_a_q + 32'd1;
                        end
                    end
                end
            end
            LS_WRITE: begin
                if (stage_q == cur_size_q - 3'd1) begin
                    state_d  = IDLE;
                    stage_d  = 3'd0;
                    ok_lsb_d = 1'b1;
                end else begin
                    stage_d    = stage_q + 3'd1;
                    mem_a_d    = mem_a_q + 32'd1;
                    mem_dout_d = cur_data_q[7:0];
                    cur_data_d = {8'd0, cur_data_q[23:8]};
                    mem_wr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            stage_q      <= 3'd0;
            if_pending_q <= 1'b0;
            ls_pending_q <= 1'b0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            ok_if_q      <= 1'b0;
            ok_lsb_q     <= 1'b0;
            inst_q       <= 32'd0;
            ldata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            if_pending_q <= if_pending_d;
            ls_pending_q <= ls_pending_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            ok_if_q      <= ok_if_d;
            ok_lsb_q     <= ok_lsb_d;
            inst_q       <= inst_d;
            ldata_q      <= ldata_d;
        end
    end

    // Request payloads and byte buffers are qualified by the control state.
    always_ff @(posedge clk) begin
        if_pc_q    <= if_pc_d;
        ls_wr_q    <= ls_wr_d;
        ls_addr_q  <= ls_addr_d;
        ls_size_q  <= ls_size_d;
        ls_data_q  <= ls_data_d;
        cur_size_q <= cur_size_d;
        cur_data_q <= cur_data_d;
        rbuf_q     <= rbuf_d;
    end

    assign ok_flag_to_if  = ok_if_q;
    assign inst_to_if     = inst_q;
    assign ok_flag_to_lsb = ok_lsb_q;
    assign data_to_lsb    = ldata_q;
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_wr         = mem_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-addressed reference memory predicts every
// fetch/load word; a monitor pops expectations on each ok pulse.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [31:0] pc_from_if;
    logic        ena_from_if, drop_flag_from_if, ok_flag_to_if;
    logic [31:0] inst_to_if;
    logic        ena_from_lsb, wr_flag_from_lsb;
    logic [31:0] addr_from_lsb;
    logic [2:0]  size_from_lsb;
    logic [31:0] data_from_lsb;
    logic        ok_flag_to_lsb;
    logic [31:0] data_to_lsb;
    logic        rollback_flag_from_rob, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_from_if(pc_from_if), .ena_from_if(ena_from_if),
        .drop_flag_from_if(drop_flag_from_if), .ok_flag_to_if(ok_flag_to_if),
        .inst_to_if(inst_to_if), .ena_from_lsb(ena_from_lsb),
        .wr_flag_from_lsb(wr_flag_from_lsb), .addr_from_lsb(addr_from_lsb),
        .size_from_lsb(size_from_lsb), .data_from_lsb(data_from_lsb),
        .ok_flag_to_lsb(ok_flag_to_lsb), .data_to_lsb(data_to_lsb),
        .rollback_flag_from_rob(rollback_flag_from_rob), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Power-on RAM contents: a short program at 4..7, a hash elsewhere.
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'd4:   return 8'h13;
            32'd5:   return 8'h05;
            32'd6:   return 8'hA0;
            32'd7:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ {a[17:16], 6'h2A};
        endcase
    endfunction

    logic [7:0] ram [0:4095];
    bit         written [0:4095];
    int         wr_cycles = 0;

    function automatic logic [11:0] idx(input logic [31:0] a);
        return {a[16], a[10:0]};
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return written[idx(a)] ? ram[idx(a)] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        mem_din <= ram_rd(mem_a);
        if (mem_wr) begin
            ram[idx(mem_a)]     <= mem_dout;
            written[idx(mem_a)] <= 1'b1;
            wr_cycles           <= wr_cycles + 1;
        end
    end

    // Reference memory, updated in program order when a store is issued.
    logic [7:0] ref_ram [logic [31:0]];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = ref_rd(a + 32'(k));
        return w;
    endfunction

    typedef struct packed { logic st; logic [31:0] d; } lsb_exp_t;
    logic [31:0] if_q [$];
    lsb_exp_t    lsb_q [$];

    int errors = 0, checks = 0, exp_writes = 0;
    int if_oks = 0, lsb_oks = 0, last_if_cyc = 0, last_lsb_cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    initial begin
        lsb_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ok_flag_to_if) begin
                    if_oks++;
                    last_if_cyc = cyc;
                    if (if_q.size() == 0) fail_now("unexpected ok_flag_to_if");
                    else check("inst_to_if", inst_to_if, if_q.pop_front());
                end
                if (ok_flag_to_lsb) begin
                    lsb_oks++;
                    last_lsb_cyc = cyc;
                    if (lsb_q.size() == 0) fail_now("unexpected ok_flag_to_lsb");
                    else begin
                        e = lsb_q.pop_front();
                        if (!e.st) check("data_to_lsb", data_to_lsb, e.d);
                    end
                end
            end
        end
    end

    task automatic pe();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ok(input bit is_if, input int n0);
        int w;
        w = 0;
        while (((is_if ? if_oks : lsb_oks) == n0) && w < 300) begin
            pe();
            w++;
        end
        if (w >= 300) fail_now(is_if ? "timeout ok_flag_to_if" : "timeout ok_flag_to_lsb");
    endtask

    // kind: 0 fetch, 1 load, 2 store; r = cycles rdy is held low from the request cycle.
    task automatic do_txn(input int kind, input logic [31:0] addr, input int n,
                          input logic [31:0] data, input int r);
        int t0, n0, lat;
        if (kind == 2) begin
            for (int k = 0; k < n; k++) ref_ram[addr + 32'(k)] = data[8*k +: 8];
            exp_writes += n;
            lsb_q.push_back('{st: 1'b1, d: 32'd0});
            lat = r + n + 1;
        end else begin
            if (kind == 0) if_q.push_back(exp_read(addr, n));
            else lsb_q.push_back('{st: 1'b0, d: exp_read(addr, n)});
            lat = r + n + 2;
        end
        t0  = cyc;
        n0  = (kind == 0) ? if_oks : lsb_oks;
        rdy = (r == 0);
        if (kind == 0) begin
            ena_from_if = 1'b1;
            pc_from_if  = addr;
        end else begin
            ena_from_lsb     = 1'b1;
            wr_flag_from_lsb = (kind == 2);
            addr_from_lsb    = addr;
            size_from_lsb    = 3'(n);
            data_from_lsb    = data;
        end
        pe();
        ena_from_if  = 1'b0;
        ena_from_lsb = 1'b0;
        for (int c = 1; c <= r; c++) begin
            if (c == r) rdy = 1'b1;
            pe();
        end
        for (int k = 0; k < n; k++) begin
            check("issue mem_a", mem_a, addr + 32'(k));
            check("issue mem_wr", {31'd0, mem_wr}, {31'd0, kind == 2});
            if (kind == 2) check("issue mem_dout", {24'd0, mem_dout}, {24'd0, data[8*k +: 8]});
            pe();
        end
        check("mem_wr after issue", {31'd0, mem_wr}, 32'd0);
        wait_ok(kind == 0, n0);
        check("latency", 32'((kind == 0 ? last_if_cyc : last_lsb_cyc) - t0), 32'(lat));
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int t0, n_if, n_l;
        rst = 1'b1; rdy = 1'b1;
        pc_from_if = 32'd0; ena_from_if = 1'b0; drop_flag_from_if = 1'b0;
        ena_from_lsb = 1'b0; wr_flag_from_lsb = 1'b0; addr_from_lsb = 32'd0;
        size_from_lsb = 3'd0; data_from_lsb = 32'd0;
        rollback_flag_from_rob = 1'b0; io_buffer_full = 1'b0;
        repeat (3) pe();
        rst = 1'b0;
        check("reset ok_flag_to_if", {31'd0, ok_flag_to_if}, 32'd0);
        check("reset inst_to_if", inst_to_if, 32'd0);
        check("reset ok_flag_to_lsb", {31'd0, ok_flag_to_lsb}, 32'd0);
        check("reset data_to_lsb", data_to_lsb, 32'd0);
        check("reset mem_wr", {31'd0, mem_wr}, 32'd0);
        check("reset mem_a", mem_a, 32'd0);
        check("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        pe();

        // Single fetch of the word at 4.
        do_txn(0, 32'h4, 4, 32'd0, 0);
        pe();

        // Fetch and load in the same cycle: load first.
        lsb_q.push_back('{st: 1'b0, d: exp_read(32'h300, 4)});
        if_q.push_back(exp_read(32'h4, 4));
        t0 = cyc; n_if = if_oks; n_l = lsb_oks;
        ena_from_if = 1'b1; pc_from_if = 32'h4;
        ena_from_lsb = 1'b1; wr_flag_from_lsb = 1'b0; addr_from_lsb = 32'h300; size_from_lsb = 3'd4;
        pe();
        ena_from_if = 1'b0; ena_from_lsb = 1'b0;
        wait_ok(1'b0, n_l);
        wait_ok(1'b1, n_if);
        check("priority load latency", 32'(last_lsb_cyc - t0), 32'd6);
        check("priority fetch latency", 32'(last_if_cyc - t0), 32'd12);
        pe();

        // 2-byte store; neighbour byte must stay untouched.
        do_txn(2, 32'h100, 2, 32'h1234ABCD, 0);
        pe();
        check("ram 0x100", {24'd0, ram_rd(32'h100)}, 32'hCD);
        check("ram 0x101", {24'd0, ram_rd(32'h101)}, 32'hAB);
        check("ram 0x102 untouched", {24'd0, ram_rd(32'h102)}, {24'd0, init_byte(32'h102)});

        // I/O store held off by io_buffer_full; a later fetch must not jump ahead.
        ref_ram[32'h30000] = 8'h5A;
        exp_writes++;
        lsb_q.push_back('{st: 1'b1, d: 32'd0});
        if_q.push_back(exp_read(32'h8, 4));
        t0 = cyc; n_if = if_oks; n_l = lsb_oks;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin
                ena_from_lsb = 1'b1; wr_flag_from_lsb = 1'b1; addr_from_lsb = 32'h30000;
                size_from_lsb = 3'd1; data_from_lsb = 32'h0000005A;
            end
            if (c == 1) begin
                ena_from_lsb = 1'b0; ena_from_if = 1'b1; pc_from_if = 32'h8;
            end
            if (c == 2) ena_from_if = 1'b0;
            io_buffer_full = (c < 5);
            check("io blocked mem_wr", {31'd0, mem_wr}, 32'd0);
            pe();
        end
        check("io store mem_wr", {31'd0, mem_wr}, 32'd1);
        check("io store mem_a", mem_a, 32'h30000);
        check("io store mem_dout", {24'd0, mem_dout}, 32'h5A);
        wait_ok(1'b0, n_l);
        wait_ok(1'b1, n_if);
        check("io store latency", 32'(last_lsb_cyc - t0), 32'd7);
        check("fetch after io store latency", 32'(last_if_cyc - t0), 32'd13);
        pe();

        // Fetch dropped at stage 2, then a drop that coincides with a new pulse.
        n_if = if_oks;
        ena_from_if = 1'b1; pc_from_if = 32'h20;
        pe();
        ena_from_if = 1'b0;
        pe(); pe();
        drop_flag_from_if = 1'b1;
        pe();
        drop_flag_from_if = 1'b0;
        repeat (8) pe();
        check("dropped fetch ok count", 32'(if_oks), 32'(n_if));
        ena_from_if = 1'b1; drop_flag_from_if = 1'b1; pc_from_if = 32'h24;
        pe();
        ena_from_if = 1'b0; drop_flag_from_if = 1'b0;
        repeat (8) pe();
        check("drop vs pulse ok count", 32'(if_oks), 32'(n_if));
        do_txn(0, 32'h40, 4, 32'd0, 0);
        pe();

        // Load rolled back in flight while a store waits behind it.
        n_l = lsb_oks;
        ref_ram[32'h210] = 8'h77;
        exp_writes++;
        lsb_q.push_back('{st: 1'b1, d: 32'd0});
        ena_from_lsb = 1'b1; wr_flag_from_lsb = 1'b0; addr_from_lsb = 32'h200; size_from_lsb = 3'd4;
        pe();
        wr_flag_from_lsb = 1'b1; addr_from_lsb = 32'h210; size_from_lsb = 3'd1; data_from_lsb = 32'h77;
        pe();
        ena_from_lsb = 1'b0; rollback_flag_from_rob = 1'b1;
        pe();
        rollback_flag_from_rob = 1'b0;
        wait_ok(1'b0, n_l);
        repeat (10) pe();
        check("rollback ok count", 32'(lsb_oks), 32'(n_l + 1));

        // Address wrap across 0xFFFFFFFF.
        do_txn(1, 32'hFFFFFFFE, 4, 32'd0, 0);
        pe();
        do_txn(2, 32'hFFFFFFFF, 2, 32'h0000BEEF, 0);
        pe();
        do_txn(1, 32'hFFFFFFFF, 2, 32'd0, 0);
        pe();

        for (int i = 0; i < 40; i++) begin
            int kind, n, r;
            logic [31:0] a, d;
            kind = int'($urandom_range(0, 2));
            n    = (kind == 0) ? 4 : (1 << $urandom_range(0, 2));
            a    = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 3)))
                                               : (32'h400 + 32'($urandom_range(0, 63)));
            d    = $urandom;
            r    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_txn(kind, a, n, d, r);
            if ($urandom_range(0, 1) == 1) pe();
        end
        repeat (4) pe();

        foreach (ref_ram[a]) check("final ram byte", {24'd0, ram_rd(a)}, {24'd0, ref_ram[a]});
        check("total write cycles", 32'(wr_cycles), 32'(exp_writes));
        check("fetch queue drained", 32'(if_q.size()), 32'd0);
        check("lsb queue drained", 32'(lsb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
